// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_t          - loader FSM states
//   DEFAULT_DEPTH    - default instruction memory depth in words
//   DEFAULT_ADDR_W   - default word-address width (log2 of depth)
//   HDR_LEN/CSUM_LEN - byte counts of the length header and checksum trailer
package imem_loader_pkg;

    localparam int DEFAULT_DEPTH  = 64;
    localparam int DEFAULT_ADDR_W = 6;

    localparam int HDR_LEN  = 2;
    localparam int CSUM_LEN = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs a big-endian byte stream into 32-bit words.
//   clk, reset   - clock and synchronous active-high reset
//   clear        - restart byte alignment (next byte is a word's MSB)
//   byte_valid   - a byte is consumed this cycle
//   byte_data    - the byte
//   word         - assembled word (registered)
//   word_valid   - one-cycle strobe, the cycle after a word's 4th byte
//   byte_idx     - position of the next byte within its word (0 = MSB)
module imem_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [1:0]  byte_idx
);

    logic [31:0] word_reg;
    logic [1:0]  idx_reg;
    logic        valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg  <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= byte_valid && (idx_reg == 2'd3);
            if (clear) begin
                idx_reg <= '0;
            end else if (byte_valid) begin
                // MSB arrives first, so shift left and append at the bottom.
                word_reg <= {word_reg[23:0], byte_data};
                idx_reg  <= idx_reg + 2'd1;
            end
        end
    end

    assign word       = word_reg;
    assign word_valid = valid_reg;
    assign byte_idx   = idx_reg;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed program image from a
// byte stream into the instruction memory write port, holding the CPU until
// the image is complete and verified.
//   clk, reset            - clock and synchronous active-high reset
//   start                 - begin a load (honoured in IDLE, DONE, ERROR)
//   in_valid/in_data      - byte stream; in_ready accepts it
//   imem_we/addr/wdata    - instruction memory write port (word addressed)
//   cpu_hold              - pipeline stall, low only with a verified image
//   load_done / load_err  - completion status levels
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    state_t            state_reg, state_next;
    logic [7:0]        len_hi_reg;
    logic [ADDR_W:0]   n_reg;
    logic [ADDR_W:0]   word_cnt_reg;
    logic [7:0]        csum_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              in_ready_reg, cpu_hold_reg, done_reg, err_reg;

    logic        accept;
    logic        restart;
    logic        asm_clear;
    logic        byte_fire;
    logic [1:0]  byte_idx;
    logic [15:0] len_full;
    logic        last_word;

    assign accept    = in_valid && in_ready_reg;
    assign byte_fire = accept && (state_reg == ST_DATA);
    assign len_full  = {len_hi_reg, in_data};
    assign last_word = (word_cnt_reg == n_reg - (ADDR_W+1)'(1));

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (byte_fire),
        .byte_data  (in_data),
        .word       (imem_wdata),
        .word_valid (imem_we),
        .byte_idx   (byte_idx)
    );

    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        asm_clear  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LEN_HI;
                    restart    = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if ((len_full == 16'd0) || (len_full > 16'(DEPTH))) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next = ST_DATA;
                        asm_clear  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (byte_fire && (byte_idx == 2'd3) && last_word)
                    state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept)
                    state_next = (in_data == csum_reg) ? ST_DONE : ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LEN_HI;
                    restart    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            len_hi_reg   <= '0;
            n_reg        <= '0;
            word_cnt_reg <= '0;
            csum_reg     <= '0;
            addr_reg     <= '0;
            in_ready_reg <= 1'b0;
            cpu_hold_reg <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Output flags are derived from the next state so they line up
            // with the state register rather than lagging it by a cycle.
            in_ready_reg <= (state_next == ST_LEN_HI) || (state_next == ST_LEN_LO) ||
                            (state_next == ST_DATA)   || (state_next == ST_CHECK);
            cpu_hold_reg <= (state_next != ST_DONE);
            done_reg     <= (state_next == ST_DONE);
            err_reg      <= (state_next == ST_ERROR);

            if (accept && (state_reg == ST_LEN_HI))
                len_hi_reg <= in_data;
            if (accept && (state_reg == ST_LEN_LO)) begin
                // Only meaningful once the length passed the range check,
                // which guarantees it fits in ADDR_W+1 bits.
                n_reg        <= len_full[ADDR_W:0];
                word_cnt_reg <= '0;
            end

            if (restart) begin
                csum_reg     <= '0;
                addr_reg     <= '0;
                word_cnt_reg <= '0;
            end else begin
                if (byte_fire) begin
                    csum_reg <= csum_reg ^ in_data;
                    if (byte_idx == 2'd3)
                        word_cnt_reg <= word_cnt_reg + (ADDR_W+1)'(1);
                end
                // Advance after each write pulse; the last slot is sticky so
                // the address never wraps back to 0.
                if (imem_we && (addr_reg != ADDR_W'(DEPTH-1)))
                    addr_reg <= addr_reg + ADDR_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign imem_addr = addr_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign load_done = done_reg;
    assign load_err  = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven directed bench for imem_loader, plus hand
// sequences for gapped full-depth load, reset mid-load and ignored start.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Write monitor: counts imem_we pulses and any write seen while released.
    int wr_total    = 0;
    int we_released = 0;
    always @(negedge clk) begin
        if (imem_we) begin
            wr_total = wr_total + 1;
            if (!cpu_hold) we_released = we_released + 1;
        end
    end

    logic [31:0] img [0:63];

    typedef struct {
        logic [15:0] len;
        int          nsend;
        bit          send_cs;
        logic [7:0]  cs;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          exp_done;
        int          exp_writes;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int guard;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        in_valid = 1'b0;
        repeat (g) tick();
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) check("handshake_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] len, input int nsend, input bit send_cs,
                            input logic [7:0] cs, input int gap_max,
                            input bit exp_done, input int exp_writes);
        int base;
        base = wr_total;
        pulse_start();
        check("in_ready_after_start", 32'(in_ready), 32'd1);
        send_byte(len[15:8], gap_max);
        send_byte(len[7:0], gap_max);
        for (int w = 0; w < nsend; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(img[w][31-8*b -: 8], gap_max);
                if (b == 3) begin
                    check("we_pulse", 32'(imem_we), 32'd1);
                    check("we_addr", 32'(imem_addr), 32'(w));
                    check("we_data", imem_wdata, img[w]);
                end
            end
        end
        if (send_cs) send_byte(cs, gap_max);
        // Status must already reflect the outcome one cycle after the last handshake.
        check("load_done", 32'(load_done), 32'(exp_done));
        check("load_err", 32'(load_err), 32'(!exp_done));
        check("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
        check("in_ready_end", 32'(in_ready), 32'd0);
        repeat (3) tick();
        check("write_count", 32'(wr_total - base), 32'(exp_writes));
        check("we_after_release", 32'(we_released), 32'd0);
        check("done_level", 32'(load_done), 32'(exp_done));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] cs;
        int base;

        // Checksum of 3C 08 00 10 8D 09 00 00 is their XOR, A0.
        vecs[0] = '{16'd2, 2, 1'b1, 8'hA0, 32'h3C080010, 32'h8D090000, 1'b1, 2};
        vecs[1] = '{16'd2, 2, 1'b1, 8'h00, 32'h3C080010, 32'h8D090000, 1'b0, 2};
        vecs[2] = '{16'd2, 2, 1'b1, 8'hA0, 32'h3C080010, 32'h8D090000, 1'b1, 2};
        // DE^AD^BE^EF = 22
        vecs[3] = '{16'd1, 1, 1'b1, 8'h22, 32'hDEADBEEF, 32'h0, 1'b1, 1};
        vecs[4] = '{16'd0, 0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 0};
        vecs[5] = '{16'h0041, 0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        reset = 1'b0;
        tick();

        // in_valid held while IDLE: nothing accepted, and a start-cycle byte is ignored.
        in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_in_ready", 32'(in_ready), 32'd0);
        end
        check("idle_imem_addr", 32'(imem_addr), 32'd0);
        in_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            img[0] = vecs[v].w0;
            img[1] = vecs[v].w1;
            $display("vector %0d: len=%h checksum=%h", v, vecs[v].len, vecs[v].cs);
            run_load(vecs[v].len, vecs[v].nsend, vecs[v].send_cs, vecs[v].cs, 0,
                     vecs[v].exp_done, vecs[v].exp_writes);
        end

        // Full depth with random in_valid gaps.
        cs = 8'h00;
        for (int i = 0; i < 64; i++) begin
            img[i] = {8'(i), 8'(i*7+1), 8'hC3, 8'(255-i)};
            cs = cs ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
        end
        $display("full-depth load: N=64 checksum=%h min handshakes=%0d", cs, 4*64+HDR_LEN+CSUM_LEN);
        run_load(16'd64, 64, 1'b1, cs, 2, 1'b1, 64);
        check("addr_no_wrap", 32'(imem_addr), 32'd63);

        // Reset after 5 data bytes of an N=2 load.
        img[0] = 32'h3C080010; img[1] = 32'h8D090000;
        base = wr_total;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        for (int b = 0; b < 4; b++) send_byte(img[0][31-8*b -: 8], 0);
        send_byte(8'h8D, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("midrst_imem_addr", 32'(imem_addr), 32'd0);
        check("midrst_load_done", 32'(load_done), 32'd0);
        check("midrst_writes", 32'(wr_total - base), 32'd1);
        $display("reset mid-load: reloading full image");
        run_load(16'd2, 2, 1'b1, 8'hA0, 0, 1'b1, 2);

        // start pulsed during DATA is ignored. 12^34^56^78 = 08.
        img[0] = 32'h12345678;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        pulse_start();
        check("start_in_data_ready", 32'(in_ready), 32'd1);
        send_byte(8'h56, 0); send_byte(8'h78, 0);
        check("start_in_data_we", 32'(imem_we), 32'd1);
        check("start_in_data_addr", 32'(imem_addr), 32'd0);
        check("start_in_data_wdata", imem_wdata, 32'h12345678);
        send_byte(8'h08, 0);
        check("start_in_data_done", 32'(load_done), 32'd1);
        check("start_in_data_hold", 32'(cpu_hold), 32'd0);
        $display("start during DATA: load finished");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
